nac_rd_arbiter: RTL and testbench



---
 rtl/nac_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_nac_rd_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nac_rd_arbiter.sv
// Round-robin read arbiter: multiplexes NUM_REQ burst requesters onto a single AXI4 read master,
// one outstanding burst at a time, with a sticky protocol/response error flag.
module nac_rd_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 40,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*8-1:0]        req_len,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [DATA_W-1:0]           rd_data,
   output logic [1:0]                  rd_resp,
   output logic                        rd_last,
   output logic [NUM_REQ-1:0]          rd_valid,
   input  logic [NUM_REQ-1:0]          rd_ready,
   output logic [ADDR_W-1:0]           m_axi_araddr,
   output logic [7:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic [1:0]                  m_axi_arburst,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   input  logic [DATA_W-1:0]           m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rlast,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
   output logic                        busy,
   output logic                        err,
   input  logic                        err_clear
);
   localparam int unsigned GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned LEN_W = 8;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t             state;
   logic [GW-1:0]      last_grant;
   logic [GW-1:0]      sel;
   logic [GW-1:0]      cand;
   logic               sel_found;
   logic [ADDR_W-1:0]  sel_addr;
   logic [LEN_W-1:0]   sel_len;
   logic [LEN_W-1:0]   beat_cnt;
   logic               in_data;
   logic               ar_hs;
   logic               r_hs;
   logic               err_set;

   assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
   assign m_axi_arburst = 2'b01;

   // Round-robin search starting just after the previous owner
   always_comb begin
      sel       = last_grant;
      cand      = '0;
      sel_found = 1'b0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = GW'((32'(last_grant) + i) % NUM_REQ);
         if (!sel_found && req_valid[cand]) begin
            sel       = cand;
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (sel == GW'(k)) begin
            sel_addr = req_addr[k*ADDR_W +: ADDR_W];
            sel_len  = req_len[k*LEN_W +: LEN_W];
         end
      end
   end

   assign in_data = (state == DATA);
   assign ar_hs   = m_axi_arvalid & m_axi_arready;
   assign r_hs    = in_data & m_axi_rvalid & m_axi_rready;

   // Data path is steered combinationally to the current owner
   assign rd_data      = m_axi_rdata;
   assign rd_resp      = m_axi_rresp;
   assign rd_last      = m_axi_rlast;
   assign m_axi_rready = in_data & rd_ready[grant_id];

   always_comb begin
      req_ready = '0;
      rd_valid  = '0;
      if (ar_hs)   req_ready[grant_id] = 1'b1;
      if (in_data) rd_valid[grant_id]  = m_axi_rvalid;
   end

   // Flags a beat count that disagrees with rlast, or a SLVERR/DECERR response
   assign err_set = r_hs & ((m_axi_rlast && (beat_cnt != m_axi_arlen)) ||
                            (!m_axi_rlast && (beat_cnt == m_axi_arlen)) ||
                            (m_axi_rresp == 2'b10) || (m_axi_rresp == 2'b11));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         grant_id      <= '0;
         last_grant    <= GW'(NUM_REQ - 1);
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
         m_axi_arvalid <= 1'b0;
         busy          <= 1'b0;
         beat_cnt      <= '0;
         err           <= 1'b0;
      end else begin
         if (err_set)        err <= 1'b1;
         else if (err_clear) err <= 1'b0;

         case (state)
            IDLE: begin
               if (sel_found) begin
                  grant_id      <= sel;
                  m_axi_araddr  <= sel_addr;
                  m_axi_arlen   <= sel_len;
                  m_axi_arvalid <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ADDR;
               end
            end
            ADDR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  beat_cnt      <= '0;
                  state         <= DATA;
               end
            end
            DATA: begin
               if (r_hs) begin
                  beat_cnt <= beat_cnt + LEN_W'(1);
                  if (m_axi_rlast) begin
                     last_grant <= grant_id;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: begin
               m_axi_arvalid <= 1'b0;
               busy          <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nac_rd_arbiter.sv
// Scoreboard bench for nac_rd_arbiter: directed bursts against a small AXI read slave,
// expected AR/R traffic queued at stimulus time and popped by independent monitors.
`timescale 1ns/1ps
module tb_nac_rd_arbiter;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ADDR_W  = 40;
   localparam int unsigned DATA_W  = 32;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*ADDR_W-1:0]  req_addr;
   logic [NUM_REQ*8-1:0]       req_len;
   logic [NUM_REQ-1:0]         req_ready;
   logic [DATA_W-1:0]          rd_data;
   logic [1:0]                 rd_resp;
   logic                       rd_last;
   logic [NUM_REQ-1:0]         rd_valid;
   logic [NUM_REQ-1:0]         rd_ready;
   logic [ADDR_W-1:0]          m_axi_araddr;
   logic [7:0]                 m_axi_arlen;
   logic [2:0]                 m_axi_arsize;
   logic [1:0]                 m_axi_arburst;
   logic                       m_axi_arvalid;
   logic                       m_axi_arready;
   logic [DATA_W-1:0]          m_axi_rdata;
   logic [1:0]                 m_axi_rresp;
   logic                       m_axi_rlast;
   logic                       m_axi_rvalid;
   logic                       m_axi_rready;
   logic [1:0]                 grant_id;
   logic                       busy;
   logic                       err;
   logic                       err_clear;

   nac_rd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
      .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .grant_id(grant_id), .busy(busy), .err(err), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   typedef struct { int id; logic [ADDR_W-1:0] addr; logic [7:0] len; } ar_exp_t;
   typedef struct { int id; logic [DATA_W-1:0] data; logic last; logic [1:0] resp; } beat_exp_t;

   ar_exp_t   ar_q[$];
   beat_exp_t r_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int ar_delay = 0;
   int bad_last = -1;
   int bad_resp = -1;
   int beats_seen[NUM_REQ];
   int rr_pulses[NUM_REQ];
   bit saw_idle = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < NUM_REQ; i++) begin
         beats_seen[i] = 0;
         rr_pulses[i]  = 0;
      end
   endtask

   // Slave returns beat n of a burst at address a as data a[31:0]+n
   task automatic expect_burst(input int id, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                               input int last_idx, input int resp_beat);
      ar_q.push_back('{id, addr, len});
      for (int n = 0; n <= last_idx; n++)
         r_q.push_back('{id, DATA_W'(addr) + DATA_W'(n), (n == last_idx), (n == resp_beat) ? 2'b10 : 2'b00});
   endtask

   task automatic request(input int id, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
      int t;
      req_addr[id*ADDR_W +: ADDR_W] = addr;
      req_len[id*8 +: 8]            = len;
      req_valid[id]                 = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!req_ready[id] && t < 200);
      check("req_accept", 64'(req_ready[id]), 64'(1));
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while ((busy || r_q.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      check({name, "_done"}, 64'(t < 300), 64'(1));
      check({name, "_ar_q_empty"}, 64'(ar_q.size()), 64'(0));
   endtask

   // AR monitor: handshake contents, hold-while-stalled, req_ready pulse, IDLE gap between grants
   initial begin : ar_mon
      ar_exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (!busy) saw_idle = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rr_pulses[i]++;
            if (m_axi_arvalid && m_axi_arready) begin
               if (ar_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL ar_unexpected: got grant %0d expected no burst", grant_id);
               end else begin
                  e = ar_q.pop_front();
                  check("ar_grant",   64'(grant_id),      64'(e.id));
                  check("ar_addr",    64'(m_axi_araddr),  64'(e.addr));
                  check("ar_len",     64'(m_axi_arlen),   64'(e.len));
                  check("ar_size",    64'(m_axi_arsize),  64'(2));
                  check("ar_burst",   64'(m_axi_arburst), 64'(1));
                  check("req_ready",  64'(req_ready),     64'(1) << e.id);
                  check("idle_gap",   64'(saw_idle),      64'(1));
                  saw_idle = 1'b0;
               end
            end else if (m_axi_arvalid && ar_q.size() != 0) begin
               check("ar_hold_addr",     64'(m_axi_araddr), 64'(ar_q[0].addr));
               check("ar_hold_len",      64'(m_axi_arlen),  64'(ar_q[0].len));
               check("req_ready_stall",  64'(req_ready),    64'(0));
            end
         end
      end
   end

   // R monitor: every accepted beat must match the next expected beat
   initial begin : r_mon
      beat_exp_t b;
      forever begin
         @(negedge clk);
         if (!rst && m_axi_rvalid && m_axi_rready) begin
            if (r_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL r_unexpected: got data %0h expected no beat", rd_data);
            end else begin
               b = r_q.pop_front();
               check("rd_valid", 64'(rd_valid), 64'(1) << b.id);
               check("rd_data",  64'(rd_data),  64'(b.data));
               check("rd_last",  64'(rd_last),  64'(b.last));
               check("rd_resp",  64'(rd_resp),  64'(b.resp));
               beats_seen[b.id]++;
            end
         end
      end
   end

   // AXI read slave
   initial begin : slave
      logic [ADDR_W-1:0] a;
      int n, last_idx;
      logic hs;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      m_axi_rresp = 2'b00; m_axi_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst && m_axi_arvalid) begin
            a = m_axi_araddr;
            last_idx = (bad_last >= 0) ? bad_last : int'(m_axi_arlen);
            for (int d = 0; d < ar_delay; d++) begin @(posedge clk); #1; end
            m_axi_arready = 1'b1;
            @(posedge clk); #1;
            m_axi_arready = 1'b0;
            n = 0;
            while (n <= last_idx && !rst) begin
               m_axi_rvalid = 1'b1;
               m_axi_rdata  = DATA_W'(a) + DATA_W'(n);
               m_axi_rlast  = (n == last_idx);
               m_axi_rresp  = (n == bad_resp) ? 2'b10 : 2'b00;
               @(negedge clk);
               hs = m_axi_rready;
               @(posedge clk); #1;
               if (hs) n++;
            end
            m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int t;
      rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0; rd_ready = '1; err_clear = 1'b0;
      clear_counts();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy",    64'(busy),          64'(0));
      check("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
      check("rst_rready",  64'(m_axi_rready),  64'(0));
      check("rst_err",     64'(err),           64'(0));
      check("rst_grant",   64'(grant_id),      64'(0));
      check("rst_araddr",  64'(m_axi_araddr),  64'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // All four requesting, len=0: grants 0,1,2,3,0
      clear_counts();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[i*ADDR_W +: ADDR_W] = 40'h2000 + ADDR_W'(i) * 40'h100;
         req_len[i*8 +: 8] = 8'd0;
      end
      expect_burst(0, 40'h2000, 8'd0, 0, -1);
      expect_burst(1, 40'h2100, 8'd0, 0, -1);
      expect_burst(2, 40'h2200, 8'd0, 0, -1);
      expect_burst(3, 40'h2300, 8'd0, 0, -1);
      expect_burst(0, 40'h2000, 8'd0, 0, -1);
      req_valid = 4'hF;
      t = 0;
      while (rr_pulses[0] < 2 && t < 300) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      req_valid = '0;
      wait_done("rr");
      check("rr_pulses0", 64'(rr_pulses[0]), 64'(2));
      check("rr_pulses3", 64'(rr_pulses[3]), 64'(1));

      // Single request on 2, latency and 4 beats
      clear_counts();
      expect_burst(2, 40'h1000, 8'd3, 3, -1);
      @(posedge clk); #1;
      req_addr[2*ADDR_W +: ADDR_W] = 40'h1000; req_len[2*8 +: 8] = 8'd3; req_valid[2] = 1'b1;
      @(negedge clk);
      check("lat_arvalid_T", 64'(m_axi_arvalid), 64'(0));
      @(negedge clk);
      check("lat_arvalid_T1",  64'(m_axi_arvalid), 64'(1));
      check("lat_req_ready_T1", 64'(req_ready),    64'(4'b0100));
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      wait_done("single");
      check("single_beats", 64'(beats_seen[2]), 64'(4));
      check("single_err",   64'(err),           64'(0));
      check("single_rvalid_idle", 64'(rd_valid), 64'(0));

      // arready delayed 5 cycles; requester withdraws during ADDR
      clear_counts();
      ar_delay = 5;
      expect_burst(3, 40'h12_3456_7890, 8'd1, 1, -1);
      @(posedge clk); #1;
      req_addr[3*ADDR_W +: ADDR_W] = 40'h12_3456_7890; req_len[3*8 +: 8] = 8'd1; req_valid[3] = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      req_valid[3] = 1'b0;
      wait_done("arwait");
      ar_delay = 0;
      check("arwait_pulses", 64'(rr_pulses[3]), 64'(1));
      check("arwait_beats",  64'(beats_seen[3]), 64'(2));

      // rd_ready[1] low for 3 cycles mid-burst
      clear_counts();
      expect_burst(1, 40'h4000, 8'd5, 5, -1);
      fork
         request(1, 40'h4000, 8'd5);
         begin
            t = 0;
            while (beats_seen[1] < 2 && t < 300) begin @(negedge clk); t++; end
            @(posedge clk); #1;
            rd_ready[1] = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               check("stall_rready", 64'(m_axi_rready), 64'(0));
               @(posedge clk); #1;
            end
            rd_ready[1] = 1'b1;
         end
      join
      wait_done("stall");
      check("stall_beats", 64'(beats_seen[1]), 64'(6));

      // len=3 but rlast on beat 2
      bad_last = 2;
      expect_burst(0, 40'h5000, 8'd3, 2, -1);
      request(0, 40'h5000, 8'd3);
      wait_done("badlast");
      bad_last = -1;
      check("badlast_err", 64'(err), 64'(1));
      repeat (3) @(negedge clk);
      check("badlast_err_held", 64'(err), 64'(1));
      @(posedge clk); #1; err_clear = 1'b1;
      @(posedge clk); #1; err_clear = 1'b0;
      @(negedge clk);
      check("badlast_err_clr", 64'(err), 64'(0));

      // SLVERR on beat 1
      bad_resp = 1;
      expect_burst(0, 40'h6000, 8'd2, 2, 1);
      request(0, 40'h6000, 8'd2);
      wait_done("slverr");
      bad_resp = -1;
      check("slverr_err", 64'(err), 64'(1));
      @(posedge clk); #1; err_clear = 1'b1;
      @(posedge clk); #1; err_clear = 1'b0;
      @(negedge clk);
      check("slverr_err_clr", 64'(err), 64'(0));

      // Set and clear in the same cycle: set wins
      bad_resp = 0;
      err_clear = 1'b1;
      expect_burst(0, 40'h7000, 8'd0, 0, 0);
      fork
         request(0, 40'h7000, 8'd0);
         begin
            t = 0;
            do begin @(negedge clk); t++; end
            while (!(m_axi_rvalid && m_axi_rready && m_axi_rlast) && t < 300);
            @(negedge clk);
            check("setwins_err", 64'(err), 64'(1));
         end
      join
      wait_done("setwins");
      bad_resp = -1;
      @(negedge clk);
      check("setwins_err_after", 64'(err), 64'(0));
      @(posedge clk); #1; err_clear = 1'b0;

      // Reset mid-DATA (err set first so its reset is visible)
      clear_counts();
      bad_resp = 0;
      expect_burst(3, 40'h8000, 8'd7, 7, 0);
      fork
         request(3, 40'h8000, 8'd7);
         begin
            t = 0;
            while (beats_seen[3] < 2 && t < 300) begin @(negedge clk); t++; end
         end
      join
      check("pre_rst_err", 64'(err), 64'(1));
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("mid_rst_busy",      64'(busy),          64'(0));
      check("mid_rst_arvalid",   64'(m_axi_arvalid), 64'(0));
      check("mid_rst_rready",    64'(m_axi_rready),  64'(0));
      check("mid_rst_req_ready", 64'(req_ready),     64'(0));
      check("mid_rst_rd_valid",  64'(rd_valid),      64'(0));
      check("mid_rst_err",       64'(err),           64'(0));
      check("mid_rst_grant",     64'(grant_id),      64'(0));
      check("mid_rst_arlen",     64'(m_axi_arlen),   64'(0));
      check("mid_rst_araddr",    64'(m_axi_araddr),  64'(0));
      ar_q.delete();
      r_q.delete();
      bad_resp = -1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      saw_idle = 1'b1;

      // Post-reset arbitration starts at requester 0 even though 2 also requests
      expect_burst(0, 40'h9000, 8'd0, 0, -1);
      expect_burst(2, 40'hA000, 8'd0, 0, -1);
      fork
         request(0, 40'h9000, 8'd0);
         request(2, 40'hA000, 8'd0);
      join
      wait_done("post_rst");
      check("post_rst_err", 64'(err), 64'(0));

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
